// File: rtl/tipi_pkg.sv
// Shared definitions for the TIPI RPi-side serial port: register
// selects, default register width and the shift FSM state encoding.
package tipi_pkg;

    localparam int TIPI_WIDTH = 8;

    localparam logic [1:0] SEL_TD = 2'b00;
    localparam logic [1:0] SEL_TC = 2'b01;
    localparam logic [1:0] SEL_RD = 2'b10;
    localparam logic [1:0] SEL_RC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } tipi_state_t;

endpackage

// File: rtl/tipi_sync_edge.sv
// Multi-flop synchroniser for asynchronous RPi strobes. The level output
// is the last synchroniser stage; rise/fall are single-cycle pulses taken
// against one further registered copy of that level.
module tipi_sync_edge #(
    parameter int SYNC_FF = 2,
    parameter int W       = 1
) (
    input  logic         clk,
    input  logic         ti_reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [SYNC_FF-1:0][W-1:0] sync;
    logic [W-1:0]              prev;

    // Shift the raw input through the synchroniser and keep one delayed copy for edges.
    always_ff @(posedge clk or negedge ti_reset) begin
        if (!ti_reset) begin
            sync <= '0;
            prev <= '0;
        end else begin
            sync <= {sync[SYNC_FF-2:0], d};
            prev <= sync[SYNC_FF-1];
        end
    end

    assign q    = sync[SYNC_FF-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/tipi_rpi_shift.sv
// RPi-side serial port for the TIPI latches. One transaction per r_le
// pulse: LOAD captures TD/TC (or clears for RD/RC writes), SHIFT moves
// bits MSB first on each synchronised sclk rise, COMMIT atomically
// updates RD/RC only when exactly WIDTH bits were clocked.
module tipi_rpi_shift import tipi_pkg::*; #(
    parameter int WIDTH   = TIPI_WIDTH,
    parameter int SYNC_FF = 2
) (
    input  logic             clk,
    input  logic             ti_reset,
    input  logic [WIDTH-1:0] td_in,
    input  logic [WIDTH-1:0] tc_in,
    input  logic             r_sclk,
    input  logic             r_le,
    input  logic [1:0]       r_sel,
    input  logic             r_din,
    output logic             r_dout,
    output logic [WIDTH-1:0] rd_q,
    output logic [WIDTH-1:0] rc_q,
    output logic             xfer_err
);

    // Counter holds 0..WIDTH+1; WIDTH+1 marks "too many clocks" and sticks.
    localparam int             CW       = $clog2(WIDTH + 2);
    localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_SAT  = CW'(WIDTH + 1);

    logic sclk_rise, le_rise, le_fall;
    logic din_s;
    logic [1:0] sel_s;
    // Edge pulses of the data/select synchronisers have no consumer.
    logic sclk_fall_nc, din_rise_nc, din_fall_nc;
    logic [1:0] sel_rise_nc, sel_fall_nc;
    logic sclk_s_nc, le_s_nc;

    tipi_sync_edge #(.SYNC_FF(SYNC_FF), .W(1)) u_sync_sclk (
        .clk(clk), .ti_reset(ti_reset), .d(r_sclk),
        .q(sclk_s_nc), .rise(sclk_rise), .fall(sclk_fall_nc)
    );

    tipi_sync_edge #(.SYNC_FF(SYNC_FF), .W(1)) u_sync_le (
        .clk(clk), .ti_reset(ti_reset), .d(r_le),
        .q(le_s_nc), .rise(le_rise), .fall(le_fall)
    );

    tipi_sync_edge #(.SYNC_FF(SYNC_FF), .W(1)) u_sync_din (
        .clk(clk), .ti_reset(ti_reset), .d(r_din),
        .q(din_s), .rise(din_rise_nc), .fall(din_fall_nc)
    );

    tipi_sync_edge #(.SYNC_FF(SYNC_FF), .W(2)) u_sync_sel (
        .clk(clk), .ti_reset(ti_reset), .d(r_sel),
        .q(sel_s), .rise(sel_rise_nc), .fall(sel_fall_nc)
    );

    tipi_state_t      state, state_n;
    logic [1:0]       sel_q, sel_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    bitcnt, bitcnt_n;
    logic [WIDTH-1:0] rd_n, rc_n;
    logic             err_n;

    // State register.
    always_ff @(posedge clk or negedge ti_reset) begin
        if (!ti_reset) state <= ST_IDLE;
        else           state <= state_n;
    end

    // Next-state and datapath next values; everything holds unless a state acts on it.
    always_comb begin
        state_n  = state;
        sel_n    = sel_q;
        shreg_n  = shreg;
        bitcnt_n = bitcnt;
        rd_n     = rd_q;
        rc_n     = rc_q;
        err_n    = xfer_err;
        case (state)
            ST_IDLE: begin
                if (le_rise) begin
                    sel_n   = sel_s;
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                case (sel_q)
                    SEL_TD:  shreg_n = td_in;
                    SEL_TC:  shreg_n = tc_in;
                    default: shreg_n = '0;
                endcase
                bitcnt_n = '0;
                state_n  = ST_SHIFT;
            end
            ST_SHIFT: begin
                // A shift coincident with le_fall still lands before COMMIT.
                if (sclk_rise) begin
                    shreg_n = {shreg[WIDTH-2:0], din_s};
                    if (bitcnt != CNT_SAT) bitcnt_n = bitcnt + CW'(1);
                end
                if (le_fall) state_n = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (bitcnt == CNT_FULL) begin
                    if (sel_q == SEL_RD) rd_n = shreg;
                    if (sel_q == SEL_RC) rc_n = shreg;
                end else begin
                    err_n = 1'b1;
                end
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Datapath registers; r_dout trails the shift register MSB by one cycle.
    always_ff @(posedge clk or negedge ti_reset) begin
        if (!ti_reset) begin
            sel_q    <= SEL_TD;
            shreg    <= '0;
            bitcnt   <= '0;
            rd_q     <= '0;
            rc_q     <= '0;
            xfer_err <= 1'b0;
            r_dout   <= 1'b0;
        end else begin
            sel_q    <= sel_n;
            shreg    <= shreg_n;
            bitcnt   <= bitcnt_n;
            rd_q     <= rd_n;
            rc_q     <= rc_n;
            xfer_err <= err_n;
            r_dout   <= shreg[WIDTH-1];
        end
    end

endmodule
